// File: rtl/gtx_kcode_monitor.sv
// GTX RX K-code legality / comma-placement monitor with error counting and lock FSM.
// Optional macro GTX_KMON_DECERR_EN folds GTX disparity / not-in-table flags into lane errors.
module gtx_kcode_monitor #(
    parameter int unsigned BYTES      = 2,
    parameter logic [11:0] KMASK      = 12'hFFF,
    parameter int unsigned COMMA_LANE = BYTES - 1,
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned WIN_LEN    = 1024,
    parameter int unsigned ERR_THRESH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx_valid,
    input  logic [BYTES-1:0]     charisk,
    input  logic [8*BYTES-1:0]   gtx_rx,
`ifdef GTX_KMON_DECERR_EN
    input  logic [BYTES-1:0]     rx_disperr,
    input  logic [BYTES-1:0]     rx_notintable,
`endif
    input  logic                 clr,
    output logic                 err,
    output logic [BYTES-1:0]     err_lane,
    output logic                 err_sticky,
    output logic [CNT_W-1:0]     err_cnt,
    output logic                 link_up,
    output logic [1:0]           state
);

    localparam int unsigned LOCK_W = $clog2(LOCK_CNT + 1);
    localparam int unsigned WIN_W  = $clog2(WIN_LEN + 1);
    localparam int unsigned WERR_W = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {
        S_HUNT   = 2'b00,
        S_LOCKED = 2'b01,
        S_LOST   = 2'b10
    } fsm_t;

    fsm_t              state_q, state_d;
    logic [LOCK_W-1:0] lock_q, lock_d;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [WERR_W-1:0] werr_q, werr_d;

    logic [BYTES-1:0]  lane_err_c;
    logic              word_err_c;
    logic              comma_c;

    function automatic logic k_legal(input logic [7:0] b);
        logic ok;
        ok = 1'b0;
        case (b)
            8'h1C:   ok = KMASK[0];
            8'h3C:   ok = KMASK[1];
            8'h5C:   ok = KMASK[2];
            8'h7C:   ok = KMASK[3];
            8'h9C:   ok = KMASK[4];
            8'hBC:   ok = KMASK[5];
            8'hDC:   ok = KMASK[6];
            8'hFC:   ok = KMASK[7];
            8'hF7:   ok = KMASK[8];
            8'hFB:   ok = KMASK[9];
            8'hFD:   ok = KMASK[10];
            8'hFE:   ok = KMASK[11];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Per-lane checks; data bytes are never in error on their own.
    always_comb begin
        lane_err_c = '0;
        for (int unsigned i = 0; i < BYTES; i++) begin
            if (rx_valid && charisk[i]) begin
                if (!k_legal(gtx_rx[8*i +: 8]))
                    lane_err_c[i] = 1'b1;
                if ((gtx_rx[8*i +: 8] == 8'hBC) && (i != COMMA_LANE))
                    lane_err_c[i] = 1'b1;
            end
`ifdef GTX_KMON_DECERR_EN
            if (rx_valid && (rx_disperr[i] || rx_notintable[i]))
                lane_err_c[i] = 1'b1;
`endif
        end
    end

    assign word_err_c = |lane_err_c;
    assign comma_c    = rx_valid && charisk[COMMA_LANE]
                        && (gtx_rx[8*COMMA_LANE +: 8] == 8'hBC) && !word_err_c;

    // Lock FSM next state; threshold is checked before the window wraps.
    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        win_d   = win_q;
        werr_d  = werr_q;
        case (state_q)
            S_HUNT: begin
                if (rx_valid) begin
                    if (word_err_c) begin
                        lock_d = '0;
                    end else if (comma_c) begin
                        if (lock_q == LOCK_W'(LOCK_CNT - 1)) begin
                            state_d = S_LOCKED;
                            lock_d  = '0;
                            win_d   = '0;
                            werr_d  = '0;
                        end else begin
                            lock_d = lock_q + LOCK_W'(1);
                        end
                    end
                end
            end
            S_LOCKED: begin
                if (rx_valid) begin
                    if (word_err_c && (werr_q == WERR_W'(ERR_THRESH - 1))) begin
                        state_d = S_LOST;
                        lock_d  = '0;
                        win_d   = '0;
                        werr_d  = '0;
                    end else if (win_q == WIN_W'(WIN_LEN - 1)) begin
                        win_d  = '0;
                        werr_d = '0;
                    end else begin
                        win_d = win_q + WIN_W'(1);
                        if (word_err_c)
                            werr_d = werr_q + WERR_W'(1);
                    end
                end
            end
            S_LOST: begin
                state_d = S_HUNT;
                lock_d  = '0;
                win_d   = '0;
                werr_d  = '0;
            end
            default: begin
                state_d = S_HUNT;
                lock_d  = '0;
                win_d   = '0;
                werr_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_HUNT;
            lock_q  <= '0;
            win_q   <= '0;
            werr_q  <= '0;
            link_up <= 1'b0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            win_q   <= win_d;
            werr_q  <= werr_d;
            link_up <= (state_d == S_LOCKED);
        end
    end

    // Error reporting; clr wins over a same-cycle error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err        <= 1'b0;
            err_lane   <= '0;
            err_sticky <= 1'b0;
            err_cnt    <= '0;
        end else begin
            err      <= word_err_c;
            err_lane <= lane_err_c;
            if (clr) begin
                err_sticky <= 1'b0;
                err_cnt    <= '0;
            end else if (word_err_c) begin
                err_sticky <= 1'b1;
                if (err_cnt != {CNT_W{1'b1}})
                    err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_gtx_kcode_monitor.sv
// Randomized self-checking bench for gtx_kcode_monitor against a behavioural model.
module tb_gtx_kcode_monitor;

    localparam int unsigned BYTES      = 2;
    localparam int unsigned COMMA      = 1;
    localparam int unsigned LOCK_CNT   = 16;
    localparam int unsigned WIN_LEN    = 1024;
    localparam int unsigned ERR_THRESH = 4;
    localparam int unsigned CNT_W      = 4;
    localparam logic [11:0] TB_KMASK   = 12'hFFF;
    localparam logic [7:0]  KCODES [12] = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
                                            8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [1:0]        charisk;
    logic [15:0]       gtx_rx;
    logic              clr;
    logic              err;
    logic [1:0]        err_lane;
    logic              err_sticky;
    logic [CNT_W-1:0]  err_cnt;
    logic              link_up;
    logic [1:0]        state;
`ifdef GTX_KMON_DECERR_EN
    logic [1:0]        rx_disperr = '0;
    logic [1:0]        rx_notintable = '0;
`endif

    gtx_kcode_monitor #(
        .BYTES(BYTES), .KMASK(TB_KMASK), .COMMA_LANE(COMMA), .LOCK_CNT(LOCK_CNT),
        .WIN_LEN(WIN_LEN), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .charisk(charisk), .gtx_rx(gtx_rx),
`ifdef GTX_KMON_DECERR_EN
        .rx_disperr(rx_disperr), .rx_notintable(rx_notintable),
`endif
        .clr(clr), .err(err), .err_lane(err_lane), .err_sticky(err_sticky),
        .err_cnt(err_cnt), .link_up(link_up), .state(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: 0 hunt, 1 locked, 2 lost.
    int m_state, m_lock, m_win, m_werr, m_cnt;
    bit m_err, m_sticky;
    bit [1:0] m_lane;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [1:0] ref_lane_err(input bit v, input bit [1:0] k, input bit [15:0] d);
        bit [1:0] e;
        bit [7:0] b;
        bit found;
        e = '0;
        if (v) begin
            for (int i = 0; i < 2; i++) begin
                if (k[i]) begin
                    b = d[8*i +: 8];
                    found = 1'b0;
                    for (int c = 0; c < 12; c++)
                        if (KCODES[c] == b && TB_KMASK[c]) found = 1'b1;
                    if (!found || (b == 8'hBC && i != int'(COMMA))) e[i] = 1'b1;
                end
            end
        end
        return e;
    endfunction

    task automatic model_reset();
        m_state = 0; m_lock = 0; m_win = 0; m_werr = 0; m_cnt = 0;
        m_err = 0; m_sticky = 0; m_lane = '0;
    endtask

    task automatic model_step(input bit v, input bit [1:0] k, input bit [15:0] d, input bit c);
        bit [1:0] le;
        bit we, comma;
        le    = ref_lane_err(v, k, d);
        we    = |le;
        comma = v && k[COMMA] && d[8*COMMA +: 8] == 8'hBC && !we;
        m_lane = le;
        m_err  = we;
        if (c) begin
            m_sticky = 0; m_cnt = 0;
        end else if (we) begin
            m_sticky = 1;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        if (m_state == 2) begin
            m_state = 0; m_lock = 0; m_win = 0; m_werr = 0;
        end else if (v && m_state == 0) begin
            if (we) m_lock = 0;
            else if (comma) m_lock++;
            if (m_lock == int'(LOCK_CNT)) begin
                m_state = 1; m_lock = 0; m_win = 0; m_werr = 0;
            end
        end else if (v && m_state == 1) begin
            m_win++;
            if (we) m_werr++;
            if (m_werr >= int'(ERR_THRESH)) begin
                m_state = 2; m_win = 0; m_werr = 0;
            end else if (m_win == int'(WIN_LEN)) begin
                m_win = 0; m_werr = 0;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check_val({tag, ".err"},        32'(err),        32'(m_err));
        check_val({tag, ".err_lane"},   32'(err_lane),   32'(m_lane));
        check_val({tag, ".err_sticky"}, 32'(err_sticky), 32'(m_sticky));
        check_val({tag, ".err_cnt"},    32'(err_cnt),    32'(m_cnt));
        check_val({tag, ".state"},      32'(state),      32'(m_state));
        check_val({tag, ".link_up"},    32'(link_up),    32'(m_state == 1));
    endtask

    task automatic word(input bit v, input bit [1:0] k, input bit [15:0] d, input bit c);
        rx_valid = v; charisk = k; gtx_rx = d; clr = c;
        @(posedge clk);
        #1;
        model_step(v, k, d, c);
        compare_all("word");
    endtask

    function automatic bit [7:0] non_bc_code();
        int idx;
        idx = $urandom_range(10);
        if (idx >= 5) idx++;
        return KCODES[idx];
    endfunction

    task automatic gen_word(input int err_pct, output bit [1:0] k, output bit [15:0] d);
        if ($urandom_range(99) < err_pct) begin
            k = 2'($urandom);
            d = 16'($urandom);
            if ($urandom_range(1) == 1) d[7:0] = KCODES[$urandom_range(11)];
        end else begin
            k[1] = 1'b1;
            d[15:8] = ($urandom_range(3) != 0) ? 8'hBC : non_bc_code();
            k[0] = 1'($urandom_range(1));
            d[7:0] = k[0] ? non_bc_code() : 8'($urandom);
        end
    endtask

    task automatic relock();
        repeat (LOCK_CNT) word(1, 2'b10, 16'hBC50, 0);
        check_val("relock.state", 32'(state), 32'd1);
    endtask

    initial begin
        bit [1:0]  k;
        bit [15:0] d;
        int p0, p1, p2;

        rst_n = 1'b0; rx_valid = 0; charisk = '0; gtx_rx = '0; clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        compare_all("reset");
        rst_n = 1'b1;

        // Initial lock on 16 clean comma words.
        for (int i = 0; i < int'(LOCK_CNT); i++) begin
            word(1, 2'b10, 16'hBC50, 0);
            check_val("lock.err", 32'(err), 32'd0);
        end
        check_val("lock.state", 32'(state), 32'd1);
        check_val("lock.link_up", 32'(link_up), 32'd1);

        // Illegal K on lane 0.
        word(1, 2'b11, 16'hBC55, 0);
        check_val("illegal_k.err", 32'(err), 32'd1);
        check_val("illegal_k.lane", 32'(err_lane), 32'd1);
        check_val("illegal_k.sticky", 32'(err_sticky), 32'd1);
        check_val("illegal_k.cnt", 32'(err_cnt), 32'd1);

        // Misplaced comma, then legal K28.1 in both lanes.
        word(1, 2'b01, 16'h00BC, 0);
        check_val("bad_comma.lane", 32'(err_lane), 32'd1);
        word(1, 2'b11, 16'h3C3C, 0);
        check_val("k281.err", 32'(err), 32'd0);

        // Two more errors reach the threshold of four.
        word(1, 2'b01, 16'h0000, 0);
        word(0, 2'b01, 16'h0000, 0);
        check_val("gap.err", 32'(err), 32'd0);
        word(1, 2'b01, 16'h0000, 0);
        check_val("lost.state", 32'(state), 32'd2);
        check_val("lost.link_up", 32'(link_up), 32'd0);
        word(1, 2'b10, 16'hBC50, 0);
        check_val("lost_exit.state", 32'(state), 32'd0);

        // Three errors per window over three windows keeps lock.
        relock();
        for (int w = 0; w < 3; w++) begin
            p0 = 100 + $urandom_range(0, 150);
            p1 = p0 + 200 + $urandom_range(0, 100);
            p2 = p1 + 200 + $urandom_range(0, 100);
            for (int n = 0; n < int'(WIN_LEN); n++) begin
                if (n == p0 || n == p1 || n == p2) begin
                    word(1, 2'b01, 16'h0000, 0);
                end else begin
                    gen_word(0, k, d);
                    word(1, k, d, 0);
                end
            end
        end
        check_val("windows.state", 32'(state), 32'd1);

        // clr beats a same-cycle error, then saturation.
        word(1, 2'b01, 16'h0000, 1);
        check_val("clr.cnt", 32'(err_cnt), 32'd0);
        check_val("clr.sticky", 32'(err_sticky), 32'd0);
        repeat (20) word(1, 2'b01, 16'h0000, 0);
        check_val("sat.cnt", 32'(err_cnt), 32'd15);

        // Random traffic with varying error density.
        for (int i = 0; i < 4000; i++) begin
            gen_word((i / 500) % 2 == 0 ? 2 : 25, k, d);
            word($urandom_range(99) < 85, k, d, $urandom_range(99) < 2);
        end

        // Asynchronous reset mid-LOCKED, between edges.
        relock();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("async_rst");
        #3;
        rst_n = 1'b1;
        repeat (LOCK_CNT - 1) word(1, 2'b10, 16'hBC50, 0);
        check_val("relock15.state", 32'(state), 32'd0);
        word(1, 2'b10, 16'hBC50, 0);
        check_val("relock16.state", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
